quad_step_decoder: RTL and testbench

Decodes a two-phase quadrature input (a/b, e.g. a rotary encoder) into single-cycle count-enable pulses with direction. It generates the `en`/`dn` stimulus that the synchronous reversible binary counter consumes. Both raw inputs are synchronised and glitch-filtered. The block also keeps an internal wrap-around position with a carry/borrow pulse, so it can stand alone or drive an external counter directly.

---
 rtl/quad_pkg.sv | 54 +++++
 rtl/quad_filter.sv | 38 +++
 rtl/quad_step_decoder.sv | 82 ++++++++
 tb/tb_quad_step_decoder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared types and transition decoding for the quadrature step decoder.
// Gray-coded phase states, direction constants and the step classifier.
package quad_pkg;

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S11 = 2'b11,
    S10 = 2'b10
  } quad_state_t;

  localparam logic UP = 1'b0;
  localparam logic DN = 1'b1;

  typedef struct packed {
    logic step;
    logic dir;
    logic illegal;
  } step_t;

  function automatic quad_state_t up_next(quad_state_t s);
    quad_state_t r;
    r = S00;
    unique case (s)
      S00: r = S01;
      S01: r = S11;
      S11: r = S10;
      S10: r = S00;
      default: r = S00;
    endcase
    return r;
  endfunction

  // prev/next differ in both bits => both phases moved on one edge
  function automatic step_t decode_step(quad_state_t prev,
                                        quad_state_t next);
    step_t r;
    r = '0;
    unique case (1'b1)
      (prev == next): r = '0;
      ((prev ^ next) == 2'b11): r.illegal = 1'b1;
      (up_next(prev) == next): begin
        r.step = 1'b1;
        r.dir  = UP;
      end
      default: begin
        r.step = 1'b1;
        r.dir  = DN;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/quad_filter.sv
// Two-flop synchroniser followed by a consecutive-sample glitch filter.
// The filtered value follows only after FILT differing samples in a row.
module quad_filter #(
  parameter int FILT = 2
) (
  input  logic clk,
  input  logic mr,
  input  logic raw,
  output logic filt
);

  localparam int CW = $clog2(FILT + 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (mr) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      filt <= 1'b0;
      cnt  <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT - 1)) begin
        filt <= s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature decoder: filtered a/b pair to en/dn step pulses,
// illegal-transition flag and a wrapping position with carry.
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int FILT  = 2,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             mr,
  input  logic             a,
  input  logic             b,
  output logic             en,
  output logic             dn,
  output logic             err,
  output logic [WIDTH-1:0] pos,
  output logic             co
);

  logic        fa;
  logic        fb;
  quad_state_t cur;
  quad_state_t state;
  step_t       st;

  logic [WIDTH-1:0] pos_nx;
  logic             co_nx;
  logic             dn_nx;

  quad_filter #(.FILT(FILT)) u_fa (
    .clk (clk),
    .mr  (mr),
    .raw (a),
    .filt(fa)
  );

  quad_filter #(.FILT(FILT)) u_fb (
    .clk (clk),
    .mr  (mr),
    .raw (b),
    .filt(fb)
  );

  assign cur = quad_state_t'({fa, fb});
  assign st  = decode_step(state, cur);

  // carry/borrow comes from the value before the step
  always_comb begin
    pos_nx = pos;
    co_nx  = 1'b0;
    dn_nx  = dn;
    if (st.step) begin
      dn_nx = st.dir;
      if (st.dir == DN) begin
        pos_nx = pos - WIDTH'(1);
        co_nx  = (pos == '0);
      end else begin
        pos_nx = pos + WIDTH'(1);
        co_nx  = (pos == '1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mr) begin
      state <= S00;
      en    <= 1'b0;
      dn    <= 1'b0;
      err   <= 1'b0;
      co    <= 1'b0;
      pos   <= '0;
    end else begin
      state <= cur;
      en    <= st.step;
      err   <= st.illegal;
      co    <= co_nx;
      dn    <= dn_nx;
      pos   <= pos_nx;
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: directed vector tables, hand sequences
// and a randomized run against a behavioural reference model.
module tb_quad_step_decoder;

  localparam int FILT  = 2;
  localparam int WIDTH = 4;

  logic             clk;
  logic             mr;
  logic             a;
  logic             b;
  logic             en;
  logic             dn;
  logic             err;
  logic [WIDTH-1:0] pos;
  logic             co;

  int checks;
  int errors;

  quad_step_decoder #(.FILT(FILT), .WIDTH(WIDTH)) dut (
    .clk(clk),
    .mr (mr),
    .a  (a),
    .b  (b),
    .en (en),
    .dn (dn),
    .err(err),
    .pos(pos),
    .co (co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       ab;
    int               hold;
    int               n_en;
    int               n_err;
    int               n_co;
    logic             exp_dn;
    logic [WIDTH-1:0] exp_pos;
  } vec_t;

  // ---------------- reference model ----------------
  logic             m_s1a, m_s2a, m_s1b, m_s2b;
  logic             m_fa, m_fb, m_pa, m_pb;
  logic             q_a[$];
  logic             q_b[$];
  logic             m_en, m_dn, m_err, m_co;
  logic [WIDTH-1:0] m_pos;

  // phase position around the cycle 00,01,11,10 (gray to binary)
  function automatic int phase_idx(logic hi, logic lo);
    return 2 * int'(hi) + int'(hi ^ lo);
  endfunction

  function automatic bit last_differ(logic q[$], logic f);
    if (q.size() < FILT) return 1'b0;
    for (int i = q.size() - FILT; i < q.size(); i++)
      if (q[i] == f) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    int d;
    if (mr) begin
      {m_s1a, m_s2a, m_s1b, m_s2b} = '0;
      {m_fa, m_fb, m_pa, m_pb} = '0;
      q_a.delete();
      q_b.delete();
      {m_en, m_dn, m_err, m_co} = '0;
      m_pos = '0;
    end else begin
      m_en = 1'b0;
      m_err = 1'b0;
      m_co = 1'b0;
      d = (phase_idx(m_fa, m_fb) - phase_idx(m_pa, m_pb) + 4) % 4;
      if (d == 1) begin
        m_en = 1'b1;
        m_dn = 1'b0;
        m_co = (m_pos == {WIDTH{1'b1}});
        m_pos = m_pos + 1'b1;
      end else if (d == 3) begin
        m_en = 1'b1;
        m_dn = 1'b1;
        m_co = (m_pos == '0);
        m_pos = m_pos - 1'b1;
      end else if (d == 2) begin
        m_err = 1'b1;
      end
      m_pa = m_fa;
      m_pb = m_fb;
      q_a.push_back(m_s2a);
      q_b.push_back(m_s2b);
      if (q_a.size() > FILT) void'(q_a.pop_front());
      if (q_b.size() > FILT) void'(q_b.pop_front());
      if (last_differ(q_a, m_fa)) m_fa = m_s2a;
      if (last_differ(q_b, m_fb)) m_fb = m_s2b;
      m_s2a = m_s1a;
      m_s2b = m_s1b;
      m_s1a = a;
      m_s1b = b;
    end
  endtask

  initial begin
    m_pos = '0;
    forever begin
      @(posedge clk);
      model_edge();
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mr = 1'b1;
    a = 1'b0;
    b = 1'b0;
    cyc();
    cyc();
    mr = 1'b0;
  endtask

  task automatic apply_vec(string name, vec_t v);
    int ne, nr, nc, bad;
    logic last_en;
    ne = 0;
    nr = 0;
    nc = 0;
    bad = 0;
    last_en = 1'b0;
    {a, b} = v.ab;
    for (int i = 0; i < v.hold; i++) begin
      cyc();
      ne += int'(en);
      nr += int'(err);
      nc += int'(co);
      if (co && !en) bad++;
      if (en && last_en) bad++;
      last_en = en;
    end
    chk({name, " en pulses"}, ne, v.n_en);
    chk({name, " err pulses"}, nr, v.n_err);
    chk({name, " co pulses"}, nc, v.n_co);
    chk({name, " pulse shape"}, bad, 0);
    chk({name, " dn"}, int'(dn), int'(v.exp_dn));
    chk({name, " pos"}, int'(pos), int'(v.exp_pos));
  endtask

  vec_t fwd[8];
  vec_t wrap[2];

  initial begin
    int ne;
    int ha, hb;
    checks = 0;
    errors = 0;
    mr = 1'b1;
    a = 1'b0;
    b = 1'b0;

    //            ab     hold en err co dn  pos
    fwd[0] = '{2'b01, 6, 1, 0, 0, 1'b0, 4'd1};
    fwd[1] = '{2'b11, 6, 1, 0, 0, 1'b0, 4'd2};
    fwd[2] = '{2'b10, 6, 1, 0, 0, 1'b0, 4'd3};
    fwd[3] = '{2'b00, 6, 1, 0, 0, 1'b0, 4'd4};
    fwd[4] = '{2'b10, 6, 1, 0, 0, 1'b1, 4'd3};
    fwd[5] = '{2'b00, 6, 1, 0, 0, 1'b0, 4'd4};
    fwd[6] = '{2'b11, 6, 0, 1, 0, 1'b0, 4'd4};
    fwd[7] = '{2'b10, 6, 1, 0, 0, 1'b0, 4'd5};
    wrap[0] = '{2'b10, 6, 1, 0, 1, 1'b1, 4'd15};
    wrap[1] = '{2'b00, 6, 1, 0, 1, 1'b0, 4'd0};

    // reset state and quiet hold
    cyc();
    cyc();
    chk("reset outputs", int'({en, dn, err, co, pos}), 0);
    mr = 1'b0;
    ne = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if ({en, dn, err, co, pos} != '0) ne++;
    end
    chk("quiet after reset", ne, 0);

    // latency: en registers on the 4th edge after the capture edge
    b = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    chk("latency en early", int'(en), 0);
    cyc();
    chk("latency en", int'(en), 1);
    chk("latency pos", int'(pos), 1);
    cyc();
    chk("latency single", int'(en), 0);

    do_reset();
    foreach (fwd[i]) apply_vec($sformatf("fwd%0d", i), fwd[i]);

    do_reset();
    foreach (wrap[i]) apply_vec($sformatf("wrap%0d", i), wrap[i]);

    // one-cycle glitch on a is rejected
    a = 1'b1;
    cyc();
    a = 1'b0;
    ne = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      ne += int'(en | err);
    end
    chk("glitch en", ne, 0);
    chk("glitch pos", int'(pos), 0);

    // a held high from 00 gives exactly one step (down)
    a = 1'b1;
    ne = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      ne += int'(en);
    end
    chk("held a en", ne, 1);
    chk("held a pos", int'(pos), 15);
    chk("held a dn", int'(dn), 1);

    // reset while a filter count is running
    b = 1'b1;
    cyc();
    cyc();
    cyc();
    mr = 1'b1;
    a = 1'b0;
    b = 1'b0;
    cyc();
    chk("midreset outputs", int'({en, dn, err, co, pos}), 0);
    mr = 1'b0;
    ne = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      ne += int'(en | err);
    end
    chk("midreset no step", ne, 0);
    chk("midreset pos", int'(pos), 0);

    // randomized run against the model
    do_reset();
    ha = $urandom_range(1, 6);
    hb = $urandom_range(1, 6);
    for (int i = 0; i < 4000; i++) begin
      mr = ($urandom_range(0, 399) == 0);
      if (--ha == 0) begin
        a = ~a;
        ha = $urandom_range(1, 7);
      end
      if (--hb == 0) begin
        b = ~b;
        hb = $urandom_range(1, 7);
      end
      cyc();
      chk("rand outputs", int'({en, dn, err, co, pos}),
          int'({m_en, m_dn, m_err, m_co, m_pos}));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
